spi_xfer_ctrl: RTL and testbench

Sequencer for the 32-bit SPI transmit shift register in `spidev`. It accepts one word per handshake and drives the shift register's load and shift clock. It generates the mode-0 SPI bus (`sclk`, `cs_n`), forwards the register's serial output as `mosi`, and captures `miso` into a receive word. It sits between the host-side register interface and the external SPI device.

---
 rtl/spi_xfer_ctrl_pkg.sv | 17 +
 rtl/spi_xfer_ctrl_if.sv | 32 +++
 rtl/spi_xfer_ctrl_half_div.sv | 27 ++
 rtl/spi_xfer_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SHIFT,
        HOLD,
        FINISH
    } spi_state_t;

    // Wide enough for CLK_DIV up to 255.
    localparam int DIV_CNT_W  = 8;
    localparam int WORD_W_DEF = 32;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host, shift-register and SPI-pin signals of the transfer sequencer.
interface spi_xfer_ctrl_if
    import spi_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [WORD_W-1:0] rx_data;
    logic [WORD_W-1:0] sr_data;
    logic              sr_load;
    logic              sr_clk;
    logic              sr_out;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    modport master (
        output start, abort, tx_data, sr_out, miso,
        input  busy, done, aborted, rx_data, sr_data, sr_load, sr_clk, sclk, cs_n, mosi
    );

    modport slave (
        input  start, abort, tx_data, sr_out, miso,
        output busy, done, aborted, rx_data, sr_data, sr_load, sr_clk, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_xfer_ctrl_half_div.sv
// Half-period timer: o_tick marks the last clk cycle of each CLK_DIV-cycle half-period.
module spi_half_div
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_restart,
    output logic o_tick
);
    localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI transfer sequencer driving an external 32-bit transmit shift register.
// Define SPI_RX_CAPTURE_EN to build the miso synchroniser and receive path.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_xfer_ctrl_if.slave bus
);
    localparam int               BIT_W    = $clog2(WORD_W) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W);

    spi_state_t        r_state, w_state_nxt;
    logic              r_half, w_half_nxt;
    logic [BIT_W-1:0]  r_bitcnt;
    logic              r_abort;
    logic              w_tick, w_restart, w_abort_req;
    logic              w_sclk_nxt, w_sr_clk_nxt, w_cs_n_nxt;
    logic              r_busy, r_done, r_aborted, r_sr_load, r_sr_clk, r_sclk, r_cs_n;
    logic [WORD_W-1:0] r_sr_data;

    spi_half_div #(.CLK_DIV(CLK_DIV)) u_half_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_abort_req = bus.abort | r_abort;

    // r_half = 0 is the first (SCLK/sr_clk high) half of a LOAD or SHIFT period.
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        unique case (r_state)
            IDLE:   if (bus.start) w_state_nxt = LOAD;
            LOAD: begin
                if (w_tick) begin
                    if (w_abort_req)  w_state_nxt = HOLD;
                    else if (r_half)  w_state_nxt = SETUP;
                    else              w_half_nxt  = 1'b1;
                end
            end
            SETUP:  if (w_tick) w_state_nxt = w_abort_req ? HOLD : SHIFT;
            SHIFT: begin
                if (w_tick) begin
                    if (w_abort_req || (r_half && (r_bitcnt == BIT_LAST))) w_state_nxt = HOLD;
                    else                                                   w_half_nxt  = ~r_half;
                end
            end
            HOLD:   if (w_tick) w_state_nxt = FINISH;
            FINISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_restart = (w_state_nxt != r_state);
        if (w_restart) w_half_nxt = 1'b0;
    end

    // Pin values are decoded from the next state so the outputs come straight from flops.
    assign w_sclk_nxt   = (w_state_nxt == SHIFT) && !w_half_nxt;
    assign w_sr_clk_nxt = ((w_state_nxt == LOAD) || (w_state_nxt == SHIFT)) && !w_half_nxt;
    assign w_cs_n_nxt   = !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT) || (w_state_nxt == HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_half    <= 1'b0;
            r_bitcnt  <= '0;
            r_abort   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_sr_load <= 1'b0;
            r_sr_clk  <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            if (w_restart)
                r_bitcnt <= '0;
            else if ((r_state == SHIFT) && w_tick && !r_half)
                r_bitcnt <= r_bitcnt + BIT_W'(1);
            if ((r_state == IDLE) || (r_state == FINISH))
                r_abort <= 1'b0;
            else if (bus.abort && (r_state inside {LOAD, SETUP, SHIFT}))
                r_abort <= 1'b1;
            r_busy    <= !((w_state_nxt == IDLE) || (w_state_nxt == FINISH));
            r_done    <= (w_state_nxt == FINISH) && !r_abort;
            r_aborted <= (w_state_nxt == FINISH) && r_abort;
            r_sr_load <= (w_state_nxt == LOAD);
            r_sr_clk  <= w_sr_clk_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cs_n    <= w_cs_n_nxt;
            if ((r_state == IDLE) && bus.start)
                r_sr_data <= bus.tx_data;
        end
    end

`ifdef SPI_RX_CAPTURE_EN
    logic [1:0]        r_miso_sync;
    logic [WORD_W-1:0] r_rx_shift, r_rx_data;
    logic              w_rise;

    assign w_rise = w_sclk_nxt && !r_sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_sync <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
        end else begin
            r_miso_sync <= {r_miso_sync[0], bus.miso};
            if (w_rise)
                r_rx_shift <= {r_rx_shift[WORD_W-2:0], r_miso_sync[1]};
            if ((r_state == HOLD) && (w_state_nxt == FINISH) && !r_abort)
                r_rx_data <= r_rx_shift;
        end
    end

    assign bus.rx_data = r_rx_data;
`else
    assign bus.rx_data = '0;
`endif

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.aborted = r_aborted;
    assign bus.sr_data = r_sr_data;
    assign bus.sr_load = r_sr_load;
    assign bus.sr_clk  = r_sr_clk;
    assign bus.sclk    = r_sclk;
    assign bus.cs_n    = r_cs_n;
    assign bus.mosi    = r_cs_n ? 1'b0 : bus.sr_out;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a shift-register model and a mode-0 device model.
module tb_spi_xfer_ctrl;
    localparam int CLK_DIV = 2;
    localparam int WORD_W  = 32;
    localparam int LAT     = 1 + 68 * CLK_DIV;
    localparam int BUDGET  = 400;
`ifdef SPI_RX_CAPTURE_EN
    localparam logic [31:0] RX_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] RX_MASK = 32'h0000_0000;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.WORD_W(WORD_W)) bus();

    spi_xfer_ctrl #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // External shift register: acts on the falling edge of sr_clk.
    logic [31:0] sr_model = '0;
    always @(negedge bus.sr_clk) begin
        if (bus.sr_load === 1'b1) sr_model <= bus.sr_data;
        else                      sr_model <= sr_model << 1;
    end
    assign bus.sr_out = sr_model[31];

    // Device: presents the next bit just after each SCLK rising edge, MSB first.
    int          rise_total = 0;
    int          rise_base  = 0;
    int          rel;
    logic [31:0] dev_word   = '0;
    logic [31:0] mosi_hist  = '0;
    assign rel      = rise_total - rise_base;
    assign bus.miso = (rel >= 0 && rel < 32) ? dev_word[31 - rel] : 1'b0;

    always @(posedge bus.sclk) begin
        rise_total = rise_total + 1;
        @(negedge clk);
        mosi_hist = {mosi_hist[30:0], bus.mosi};
    end

    int done_cnt = 0;
    int abt_cnt  = 0;
    always @(negedge clk) begin
        if (bus.done === 1'b1)    done_cnt = done_cnt + 1;
        if (bus.aborted === 1'b1) abt_cnt  = abt_cnt + 1;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] tx, input logic [31:0] dev);
        dev_word  = dev;
        rise_base = rise_total;
        @(negedge clk);
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tx_data = ~tx;
    endtask

    // lat is the index of the current cycle counted from the start-accepting edge.
    task automatic wait_done(input bit phases, input int poke, input logic [31:0] tx, output int lat);
        lat = 1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (phases) begin
                if (lat == 1) begin
                    chk("load_sr_load", bus.sr_load, 1'b1);
                    chk("load_sr_clk_hi", bus.sr_clk, 1'b1);
                    chk("load_busy", bus.busy, 1'b1);
                    chk("load_cs_n", bus.cs_n, 1'b1);
                    chk("load_sr_data", bus.sr_data, tx);
                end
                if (lat == 1 + CLK_DIV) begin
                    chk("load_sr_clk_lo", bus.sr_clk, 1'b0);
                    chk("load_sr_load_2nd", bus.sr_load, 1'b1);
                end
                if (lat == 1 + 2 * CLK_DIV) begin
                    chk("setup_cs_n", bus.cs_n, 1'b0);
                    chk("setup_sr_load", bus.sr_load, 1'b0);
                    chk("setup_sclk", bus.sclk, 1'b0);
                    chk("setup_mosi_msb", bus.mosi, tx[31]);
                end
                if (lat == 1 + 3 * CLK_DIV) chk("shift_first_sclk", bus.sclk, 1'b1);
            end
            if (poke > 0 && lat == poke) begin
                bus.start   = 1'b1;
                bus.tx_data = 32'hDEAD_BEEF;
            end
            if (poke > 0 && lat == poke + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) break;
            @(posedge clk);
            lat = lat + 1;
        end
        if (bus.done !== 1'b1) chk("done_wait", bus.done, 1'b1);
    endtask

    task automatic wait_rise(input int n);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (rel >= n) break;
        end
        if (rel < n) chk("rise_wait", rel, n);
    endtask

    initial begin
        int          lat;
        int          d0, a0, gap;
        logic [31:0] exp_rx;

        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.tx_data = '0;
        exp_rx      = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_aborted", bus.aborted, 1'b0);
        chk("rst_sr_load", bus.sr_load, 1'b0);
        chk("rst_sr_clk", bus.sr_clk, 1'b0);
        chk("rst_sclk", bus.sclk, 1'b0);
        chk("rst_cs_n", bus.cs_n, 1'b1);
        chk("rst_mosi", bus.mosi, 1'b0);
        chk("rst_rx_data", bus.rx_data, 32'h0);
        chk("rst_sr_data", bus.sr_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single transfer with phase checks.
        start_xfer(32'hA5C3_0F96, 32'h1234_5678);
        wait_done(1'b1, 0, 32'hA5C3_0F96, lat);
        exp_rx = 32'h1234_5678 & RX_MASK;
        chk("t1_latency", lat, LAT);
        chk("t1_rx_data", bus.rx_data, exp_rx);
        chk("t1_mosi_word", mosi_hist, 32'hA5C3_0F96);
        chk("t1_rises", rel, 32);
        chk("t1_busy_in_finish", bus.busy, 1'b0);
        chk("t1_cs_n_in_finish", bus.cs_n, 1'b1);
        @(negedge clk);
        chk("t1_done_one_cycle", bus.done, 1'b0);

        // A start while busy is dropped.
        d0 = done_cnt;
        start_xfer(32'h0F0F_0F0F, 32'hCAFE_F00D);
        wait_done(1'b0, 40, 32'h0F0F_0F0F, lat);
        exp_rx = 32'hCAFE_F00D & RX_MASK;
        chk("t2_latency", lat, LAT);
        chk("t2_rx_data", bus.rx_data, exp_rx);
        chk("t2_mosi_word", mosi_hist, 32'h0F0F_0F0F);
        repeat (20) @(negedge clk);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_busy_after", bus.busy, 1'b0);
        chk("t2_sr_data_kept", bus.sr_data, 32'h0F0F_0F0F);

        // Abort while SCLK is high on bit 10.
        d0 = done_cnt;
        a0 = abt_cnt;
        start_xfer(32'hFFFF_0000, 32'h5A5A_5A5A);
        wait_rise(10);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("ab_sclk_still_high", bus.sclk, 1'b1);
        @(negedge clk);
        chk("ab_sclk_dropped", bus.sclk, 1'b0);
        chk("ab_hold_cs_n", bus.cs_n, 1'b0);
        chk("ab_hold_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk("ab_hold2_cs_n", bus.cs_n, 1'b0);
        chk("ab_hold2_sclk", bus.sclk, 1'b0);
        @(negedge clk);
        chk("ab_finish_cs_n", bus.cs_n, 1'b1);
        chk("ab_aborted", bus.aborted, 1'b1);
        chk("ab_no_done", bus.done, 1'b0);
        chk("ab_rx_unchanged", bus.rx_data, exp_rx);
        @(negedge clk);
        chk("ab_pulse_one_cycle", bus.aborted, 1'b0);
        chk("ab_busy_idle", bus.busy, 1'b0);
        repeat (10) @(negedge clk);
        chk("ab_rises_stopped", rel, 10);
        chk("ab_abort_count", abt_cnt - a0, 1);
        chk("ab_done_count", done_cnt - d0, 0);

        // Asynchronous reset during SHIFT.
        d0 = done_cnt;
        start_xfer(32'h8000_0001, 32'h0000_0000);
        wait_rise(5);
        chk("rs_sclk_before", bus.sclk, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rs_cs_n_now", bus.cs_n, 1'b1);
        chk("rs_sclk_now", bus.sclk, 1'b0);
        chk("rs_sr_clk_now", bus.sr_clk, 1'b0);
        chk("rs_busy_now", bus.busy, 1'b0);
        chk("rs_rx_cleared", bus.rx_data, 32'h0);
        exp_rx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rs_busy_after", bus.busy, 1'b0);
        chk("rs_cs_n_after", bus.cs_n, 1'b1);
        chk("rs_sclk_after", bus.sclk, 1'b0);
        chk("rs_no_done", done_cnt - d0, 0);

        // Back-to-back: next start in the IDLE cycle after done.
        start_xfer(32'h3C3C_1234, 32'h0F1E_2D3C);
        wait_done(1'b0, 0, 32'h3C3C_1234, lat);
        exp_rx = 32'h0F1E_2D3C & RX_MASK;
        chk("bb_a_latency", lat, LAT);
        chk("bb_a_rx_data", bus.rx_data, exp_rx);
        gap = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (i == 1) begin
                dev_word    = 32'hFFFF_FFFF;
                rise_base   = rise_total;
                bus.tx_data = 32'h6B00_00C5;
                bus.start   = 1'b1;
            end
            if (i == 2) begin
                bus.start   = 1'b0;
                bus.tx_data = '0;
            end
            if (bus.cs_n !== 1'b1) break;
            gap = gap + 1;
            @(negedge clk);
        end
        // FINISH + IDLE + LOAD
        chk("bb_cs_n_gap", gap, 2 + 2 * CLK_DIV);
        wait_done(1'b0, 0, 32'h6B00_00C5, lat);
        exp_rx = 32'hFFFF_FFFF & RX_MASK;
        chk("bb_b_rx_data", bus.rx_data, exp_rx);
        chk("bb_b_mosi_word", mosi_hist, 32'h6B00_00C5);
        chk("bb_b_rises", rel, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
